mem_arbiter: RTL and testbench

Shares the single 64 KiB × 8 synchronous video/program memory between two requesters: the video fetch unit (priority) and the CPU. Runs on the fast 100 MHz clock and serves one access per 4-cycle slot, giving a 25 MHz access rate aligned to the pixel clock. A starvation counter guarantees the CPU a slot after a bounded run of video grants.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: 4-cycle slot arbiter sharing one synchronous RAM between video (priority) and CPU,
// with a starvation counter that forces a CPU slot after STARVE_LIMIT consecutive video wins.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock_hi,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_cpu
);
    typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              grant_q, grant_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              pick_cpu;

    always_comb begin
        pick_cpu    = cpu_req && (!vid_req || starve_q >= LIMIT);
        state_d     = state_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        is_wr_d     = is_wr_q;
        grant_d     = grant_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            IDLE: if (vid_req || cpu_req) begin
                state_d     = ACCESS;
                mem_addr_d  = pick_cpu ? cpu_addr : vid_addr;
                mem_we_d    = pick_cpu && cpu_we;
                is_wr_d     = pick_cpu && cpu_we;
                mem_wdata_d = pick_cpu ? cpu_wdata : mem_wdata_q;
                grant_d     = pick_cpu;
                // counter only grows while the CPU is actually left waiting
                starve_d    = (pick_cpu || !cpu_req) ? 4'd0 :
                              (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
            end
            ACCESS: state_d = READ;
            READ: begin
                state_d     = DONE;
                vid_data_d  = grant_q ? vid_data_q : mem_rdata;
                cpu_rdata_d = (grant_q && !is_wr_q) ? mem_rdata : cpu_rdata_q;
                vid_ack_d   = !grant_q;
                cpu_ack_d   = grant_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_hi) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            is_wr_q     <= 1'b0;
            grant_q     <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            is_wr_q     <= is_wr_d;
            grant_q     <= grant_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_cpu = grant_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_data  = vid_data_q;
    assign cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized slot-level checks of mem_arbiter against a
// transaction model (reference memory, grant order from the starvation rule).
module tb_mem_arbiter;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req, cpu_req, cpu_we;
    logic [15:0] vid_addr, cpu_addr, mem_addr;
    logic [7:0]  vid_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic        vid_ack, cpu_ack, mem_we, grant_cpu;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
        .clock_hi(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_cpu(grant_cpu)
    );

    // Unwritten locations read a fixed address hash; 0x1234 hashes to 0xA5.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h83;
    endfunction

    logic [7:0] ram [0:65535];
    bit         ram_v [0:65535];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            ram_v[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

    logic [7:0]  ref_mem [0:65535];
    int          total = 0, bad = 0, starve = 0;
    logic [7:0]  exp_v, exp_c;
    logic        vp, cp, cwe, last_cpu;
    logic [15:0] va, ca;
    logic [7:0]  cwd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] raddr();
        return $urandom_range(0, 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
    endfunction

    // One full slot, entered just after the edge that starts an IDLE cycle.
    task automatic slot();
        logic c, w;
        logic [15:0] a;
        vid_req = vp; vid_addr = va;
        cpu_req = cp; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
        c = cp && (!vp || starve == LIM);
        starve = (cp && vp && !c) ? starve + 1 : 0;
        w = c && cwe;
        a = c ? ca : va;
        if (!c) exp_v = ref_mem[va];
        else if (cwe) ref_mem[ca] = cwd;
        else exp_c = ref_mem[ca];
        @(negedge clk);
        chk("idle_ack", {vid_ack, cpu_ack}, 0);
        chk("idle_we", mem_we, 0);
        @(negedge clk);
        chk("acc_addr", mem_addr, a);
        chk("acc_we", mem_we, w);
        chk("acc_grant", grant_cpu, c);
        if (w) chk("acc_wdata", mem_wdata, cwd);
        @(negedge clk);
        chk("read_we", mem_we, 0);
        chk("read_ack", {vid_ack, cpu_ack}, 0);
        @(negedge clk);
        chk("done_ack", {vid_ack, cpu_ack}, {!c, c});
        chk("vid_data", vid_data, exp_v);
        chk("cpu_rdata", cpu_rdata, exp_c);
        @(posedge clk); #1;
        if (c) begin cp = 0; cpu_req = 0; end
        else begin vp = 0; vid_req = 0; end
        last_cpu = c;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
        reset = 1; vp = 1; cp = 1; cwe = 0; va = 16'h0100; ca = 16'h0200; cwd = 0;
        vid_req = 1; cpu_req = 1; vid_addr = va; cpu_addr = ca; cpu_we = 0; cpu_wdata = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_addr", mem_addr, 0);
            chk("rst_misc", {mem_we, mem_wdata, vid_data, vid_ack, cpu_ack, grant_cpu}, 0);
            chk("rst_crd", cpu_rdata, 0);
        end
        @(posedge clk); #1;
        reset = 0; exp_v = 0; exp_c = 0; starve = 0;
        slot();
        chk("first_grant_vid", last_cpu, 0);
        slot();

        vp = 1; va = 16'h1234;
        slot();
        chk("vid_a5", vid_data, 8'hA5);

        cp = 1; cwe = 0; ca = 16'h1234; slot();
        cp = 1; cwe = 1; ca = 16'hFFFF; cwd = 8'h5A; slot();
        chk("crd_after_wr", cpu_rdata, 8'hA5);
        cp = 1; cwe = 0; slot();
        chk("rd_5a", cpu_rdata, 8'h5A);

        for (int k = 0; k < 12; k++) begin
            vp = 1; va = raddr();
            if (!cp) begin cp = 1; cwe = 0; ca = raddr(); end
            slot();
            chk("cont_seq", last_cpu, (k % 4 == 3));
        end
        cp = 0; cpu_req = 0;

        vp = 1; va = 16'h1234; vid_req = 1; vid_addr = va; cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_addr", mem_addr, 16'h1234);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_ack", {vid_ack, cpu_ack}, 0);
        chk("abort_vdata", vid_data, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_grant", grant_cpu, 0);
        exp_v = 0; exp_c = 0; starve = 0;
        slot();
        chk("after_abort", vid_data, 8'hA5);

        for (int i = 0; i < 4; i++) begin
            cp = 1; cwe = 0; ca = 16'(i);
            slot();
        end

        repeat (200) begin
            if (!vp && $urandom_range(0, 1) == 1) begin vp = 1; va = raddr(); end
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1; cwe = 1'($urandom_range(0, 1)); ca = raddr(); cwd = 8'($urandom);
            end
            if (vp || cp) slot();
            else begin
                @(negedge clk);
                chk("idle_stay", {mem_we, vid_ack, cpu_ack, grant_cpu}, 0);
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
